mem_port_arbiter: RTL and testbench

//  Shares one req/gnt/rvalid memory port between the fetch stage instruction port and the

---
 rtl/mem_arb_pkg.sv | 30 +++
 rtl/mem_arb_outst_fifo.sv | 76 +++++++
 rtl/mem_port_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: requester identity and the
// per-transaction tracking entry kept until the response returns.
package mem_arb_pkg;

  typedef enum logic {
    SRC_INSTR = 1'b0,
    SRC_DATA  = 1'b1
  } mem_src_e;

  typedef struct packed {
    mem_src_e src;
    logic     discard;
  } outst_entry_t;

  // Instruction fetches are always full-word reads.
  localparam logic [3:0] INSTR_BE = 4'hF;

  // Returns the entry with discard set when a fetch flush hits an instr entry.
  function automatic outst_entry_t mark_flush(input outst_entry_t entry, input logic flush);
    outst_entry_t res;
    res = entry;
    if (flush && (entry.src == SRC_INSTR)) begin
      res.discard = 1'b1;
    end else begin
      res.discard = entry.discard;
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_arb_outst_fifo.sv
// In-order tracking FIFO of issued-but-unanswered transactions. A flush-mark
// pulse tags every resident instruction entry so its response is dropped.
module mem_arb_outst_fifo
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  outst_entry_t     push_entry_i,
  input  logic             pop_i,
  input  logic             flush_mark_i,
  output outst_entry_t     head_o,
  output logic [CNT_W-1:0] count_o
);

  outst_entry_t     entries_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] nxt;
    if (ptr == PTR_W'(DEPTH - 1)) begin
      nxt = '0;
    end else begin
      nxt = ptr + PTR_W'(1);
    end
    return nxt;
  endfunction

  // Entry storage: flush tags instr entries, then a push overwrites the tail slot.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        entries_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        entries_r[i] <= mark_flush(entries_r[i], flush_mark_i);
      end
      if (push_i) begin
        entries_r[wr_ptr_r] <= push_entry_i;
      end
    end
  end

  // Read/write pointers and occupancy; simultaneous push and pop leaves count alone.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_i) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_i) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_i, pop_i})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head_o  = entries_r[rd_ptr_r];
  assign count_o = count_r;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one req/gnt/rvalid memory port between the fetch port and the LSU
// port: arbitration with starvation guard, request lock until granted,
// in-order response routing and fetch-flush response dropping.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned DATA_STREAK_MAX = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        instr_flush_i,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic        protocol_err_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned STK_W = $clog2(DATA_STREAK_MAX + 1);

  logic             lock_r;
  mem_src_e         owner_r;
  logic [STK_W-1:0] streak_r;
  logic             proto_err_r;

  mem_src_e         sel_src_s;
  logic             req_s;
  logic             issue_ok_s;
  logic             streak_full_s;
  logic             bus_gnt_s;
  logic             pop_s;
  outst_entry_t     head_s;
  outst_entry_t     push_entry_s;
  logic [CNT_W-1:0] count_s;

  assign issue_ok_s    = (count_s < CNT_W'(MAX_OUTSTANDING));
  assign streak_full_s = (streak_r == STK_W'(DATA_STREAK_MAX));

  // Owner selection: a locked owner keeps the bus, otherwise data wins unless instr is starved.
  always_comb begin
    sel_src_s = SRC_DATA;
    req_s     = 1'b0;
    if (!issue_ok_s) begin
      sel_src_s = SRC_DATA;
      req_s     = 1'b0;
    end else if (lock_r) begin
      sel_src_s = owner_r;
      req_s     = 1'b1;
    end else if (instr_req_i && (!data_req_i || streak_full_s)) begin
      sel_src_s = SRC_INSTR;
      req_s     = 1'b1;
    end else if (data_req_i) begin
      sel_src_s = SRC_DATA;
      req_s     = 1'b1;
    end else begin
      sel_src_s = SRC_DATA;
      req_s     = 1'b0;
    end
  end

  // Bus request fields follow the selected owner; fetches are fixed full-word reads.
  always_comb begin
    mem_req_o   = req_s;
    mem_addr_o  = 32'h0000_0000;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_wdata_o = 32'h0000_0000;
    case (sel_src_s)
      SRC_INSTR: begin
        mem_addr_o  = instr_addr_i;
        mem_we_o    = 1'b0;
        mem_be_o    = INSTR_BE;
        mem_wdata_o = 32'h0000_0000;
      end
      SRC_DATA: begin
        mem_addr_o  = data_addr_i;
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_wdata_o = data_wdata_i;
      end
      default: begin
        mem_addr_o  = 32'h0000_0000;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_wdata_o = 32'h0000_0000;
      end
    endcase
  end

  assign bus_gnt_s   = req_s & mem_gnt_i;
  assign instr_gnt_o = bus_gnt_s & (sel_src_s == SRC_INSTR);
  assign data_gnt_o  = bus_gnt_s & (sel_src_s == SRC_DATA);

  // Tracking entry for a new grant; a same-cycle flush already marks it discarded.
  always_comb begin
    push_entry_s.src     = sel_src_s;
    push_entry_s.discard = 1'b0;
    push_entry_s         = mark_flush(push_entry_s, instr_flush_i);
  end

  assign pop_s = mem_rvalid_i & (count_s != CNT_W'(0));

  mem_arb_outst_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_outst_fifo (
    .clk          (clk),
    .rstn         (rstn),
    .push_i       (bus_gnt_s),
    .push_entry_i (push_entry_s),
    .pop_i        (pop_s),
    .flush_mark_i (instr_flush_i),
    .head_o       (head_s),
    .count_o      (count_s)
  );

  // Response routing to the head's issuer; discarded or just-flushed fetches stay silent.
  always_comb begin
    instr_rvalid_o = 1'b0;
    data_rvalid_o  = 1'b0;
    if (pop_s && !head_s.discard) begin
      case (head_s.src)
        SRC_INSTR: instr_rvalid_o = ~instr_flush_i;
        SRC_DATA:  data_rvalid_o  = 1'b1;
        default: begin
          instr_rvalid_o = 1'b0;
          data_rvalid_o  = 1'b0;
        end
      endcase
    end else begin
      instr_rvalid_o = 1'b0;
      data_rvalid_o  = 1'b0;
    end
  end

  assign instr_rdata_o  = mem_rdata_i;
  assign instr_err_o    = mem_err_i;
  assign data_rdata_o   = mem_rdata_i;
  assign data_err_o     = mem_err_i;
  assign protocol_err_o = proto_err_r;

  // Lock holds the owner while its request waits for mem_gnt_i.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lock_r  <= 1'b0;
      owner_r <= SRC_INSTR;
    end else begin
      lock_r <= req_s & ~mem_gnt_i;
      if (req_s && !mem_gnt_i) begin
        owner_r <= sel_src_s;
      end
    end
  end

  // Starvation guard: count data grants that bypass a waiting fetch, saturating.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      streak_r <= '0;
    end else if (!instr_req_i || instr_gnt_o) begin
      streak_r <= '0;
    end else if (data_gnt_o && !streak_full_s) begin
      streak_r <= streak_r + STK_W'(1);
    end
  end

  // Sticky flag for a response arriving with nothing outstanding.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      proto_err_r <= 1'b0;
    end else if (mem_rvalid_i && (count_s == CNT_W'(0))) begin
      proto_err_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by a
// randomized phase, all checked each cycle against a queue-based reference.
module tb_mem_port_arbiter;

  localparam int MAXO = 3;
  localparam int STK  = 4;

  logic        clk;
  logic        rstn;
  logic        instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o, instr_flush_i;
  logic [31:0] instr_addr_i, instr_rdata_o;
  logic        data_req_i, data_we_i, data_gnt_o, data_rvalid_o, data_err_o;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, mem_err_i, protocol_err_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  mem_port_arbiter #(
    .MAX_OUTSTANDING (MAXO),
    .DATA_STREAK_MAX (STK)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .instr_req_i    (instr_req_i),
    .instr_addr_i   (instr_addr_i),
    .instr_gnt_o    (instr_gnt_o),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_rdata_o  (instr_rdata_o),
    .instr_err_o    (instr_err_o),
    .instr_flush_i  (instr_flush_i),
    .data_req_i     (data_req_i),
    .data_we_i      (data_we_i),
    .data_be_i      (data_be_i),
    .data_addr_i    (data_addr_i),
    .data_wdata_i   (data_wdata_i),
    .data_gnt_o     (data_gnt_o),
    .data_rvalid_o  (data_rvalid_o),
    .data_rdata_o   (data_rdata_o),
    .data_err_o     (data_err_o),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_we_o       (mem_we_o),
    .mem_be_o       (mem_be_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .mem_err_i      (mem_err_i),
    .protocol_err_o (protocol_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: outstanding transactions in issue order plus arbitration history.
  typedef struct {
    bit is_instr;
    bit discard;
  } ref_txn_t;
  ref_txn_t mq[$];
  bit m_held, m_held_instr, m_perr;
  int m_streak;

  // Requester agents (held until granted) and memory-side stimulus.
  bit          i_pend, d_pend, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_be;
  bit          bgnt, brv, berr, flush;
  logic [31:0] brdata;
  int          mode;  // 0 manual, 1 auto-respond, 2 random
  byte         glog[$];
  int          n_igt, n_dgt, n_irv, n_drv;

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    instr_req_i   = i_pend;
    instr_addr_i  = i_addr;
    data_req_i    = d_pend;
    data_we_i     = d_we;
    data_be_i     = d_be;
    data_addr_i   = d_addr;
    data_wdata_i  = d_wdata;
    mem_gnt_i     = bgnt;
    mem_rvalid_i  = brv;
    mem_rdata_i   = brdata;
    mem_err_i     = berr;
    instr_flush_i = flush;
  endtask

  // One clock cycle: predict, compare, then advance the reference at the edge.
  task automatic step();
    bit e_req, e_i, e_ig, e_dg, e_irv, e_drv;
    ref_txn_t t;
    if (mode == 1) begin
      brv = (mq.size() > 0);
    end else if (mode == 2) begin
      bgnt   = ($urandom_range(0, 9) < 6);
      brv    = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
      flush  = ($urandom_range(0, 19) == 0);
      brdata = $urandom();
      berr   = ($urandom_range(0, 7) == 0);
    end
    drive();
    #1;
    e_req = 1'b0;
    e_i   = 1'b0;
    if (mq.size() >= MAXO) begin
      e_req = 1'b0;
    end else if (m_held) begin
      e_req = 1'b1;
      e_i   = m_held_instr;
    end else if (i_pend && (!d_pend || m_streak == STK)) begin
      e_req = 1'b1;
      e_i   = 1'b1;
    end else if (d_pend) begin
      e_req = 1'b1;
    end
    e_ig  = e_req && e_i && bgnt;
    e_dg  = e_req && !e_i && bgnt;
    e_irv = 1'b0;
    e_drv = 1'b0;
    if (brv && mq.size() > 0 && !mq[0].discard) begin
      if (mq[0].is_instr) e_irv = !flush;
      else e_drv = 1'b1;
    end
    check1("mem_req", mem_req_o, e_req);
    if (e_req) begin
      check32("mem_addr", mem_addr_o, e_i ? i_addr : d_addr);
      check1("mem_we", mem_we_o, e_i ? 1'b0 : d_we);
      check32("mem_be", 32'(mem_be_o), e_i ? 32'hF : 32'(d_be));
      check32("mem_wdata", mem_wdata_o, e_i ? 32'h0 : d_wdata);
    end
    check1("instr_gnt", instr_gnt_o, e_ig);
    check1("data_gnt", data_gnt_o, e_dg);
    check1("instr_rvalid", instr_rvalid_o, e_irv);
    check1("data_rvalid", data_rvalid_o, e_drv);
    if (e_irv) begin
      check32("instr_rdata", instr_rdata_o, brdata);
      check1("instr_err", instr_err_o, berr);
    end
    if (e_drv) begin
      check32("data_rdata", data_rdata_o, brdata);
      check1("data_err", data_err_o, berr);
    end
    check1("protocol_err", protocol_err_o, m_perr);
    if (instr_gnt_o) begin glog.push_back("I"); n_igt++; end
    if (data_gnt_o) begin glog.push_back("D"); n_dgt++; end
    if (instr_rvalid_o) n_irv++;
    if (data_rvalid_o) n_drv++;
    @(posedge clk);
    if (brv) begin
      if (mq.size() == 0) m_perr = 1'b1;
      else void'(mq.pop_front());
    end
    if (flush) begin
      foreach (mq[k]) if (mq[k].is_instr) mq[k].discard = 1'b1;
    end
    if (e_ig || e_dg) begin
      t.is_instr = e_i;
      t.discard  = e_i && flush;
      mq.push_back(t);
    end
    m_held       = e_req && !bgnt;
    m_held_instr = e_i;
    if (!i_pend || e_ig) m_streak = 0;
    else if (e_dg && m_streak < STK) m_streak++;
    if (e_ig) i_pend = 1'b0;
    if (e_dg) d_pend = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    i_pend = 1'b0; d_pend = 1'b0; bgnt = 1'b0; brv = 1'b0; flush = 1'b0;
    drive();
    rstn = 1'b0;
    #1;
    check1("rst_protocol_err", protocol_err_o, 1'b0);
    check1("rst_mem_req", mem_req_o, 1'b0);
    check1("rst_instr_gnt", instr_gnt_o, 1'b0);
    check1("rst_data_gnt", data_gnt_o, 1'b0);
    check1("rst_instr_rvalid", instr_rvalid_o, 1'b0);
    check1("rst_data_rvalid", data_rvalid_o, 1'b0);
    mq.delete();
    m_held = 1'b0; m_perr = 1'b0; m_streak = 0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic drain();
    mode = 0; bgnt = 1'b0; i_pend = 1'b0; d_pend = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (mq.size() > 0) begin
        brv = 1'b1;
        step();
      end
    end
    brv = 1'b0;
  endtask

  initial begin
    int base;
    string exp_order;
    rstn = 1'b0; mode = 0;
    i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0; d_we = 1'b0;
    brdata = 32'h0; berr = 1'b0;
    @(negedge clk);
    do_reset();

    // 1: instr only, always granted, one-cycle response with a NOP word.
    mode = 1; bgnt = 1'b1; brdata = 32'h0000_0013;
    base = n_irv;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin i_pend = 1'b1; i_addr = 32'h100 + 32'(k * 4); end
      step();
    end
    check32("t1_instr_rvalid_count", 32'(n_irv - base), 32'd4);
    check32("t1_data_rvalid_count", 32'(n_drv), 32'd0);

    // 2: both requesting, data wins until the streak limit lets instr through.
    glog.delete();
    base = 0;
    for (int k = 0; k < 14 && glog.size() < 7; k++) begin
      if (!d_pend && base < 6) begin
        d_pend = 1'b1; d_addr = 32'h2000 + 32'(base * 4); d_we = base[0];
        d_be = 4'h3; d_wdata = 32'hCAFE_0000 + 32'(base);
        base++;
      end
      i_pend = 1'b1; i_addr = 32'h400;
      step();
    end
    i_pend = 1'b0; d_pend = 1'b0;
    step(); step();
    exp_order = "DDDDIDD";
    check32("t2_grant_count", 32'(glog.size() >= 7), 32'd1);
    for (int k = 0; k < 7 && k < glog.size(); k++) check32("t2_order", 32'(glog[k]), 32'(exp_order[k]));

    // 3: data held without grant; attributes stay put, then data, then instr.
    mode = 0; bgnt = 1'b0; brv = 1'b0; glog.delete();
    d_pend = 1'b1; d_addr = 32'hA000_0040; d_we = 1'b1; d_be = 4'h5; d_wdata = 32'h1234_5678;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin i_pend = 1'b1; i_addr = 32'h0000_0800; end
      step();
      check32("t3_addr_stable", mem_addr_o, 32'hA000_0040);
      check32("t3_wdata_stable", mem_wdata_o, 32'h1234_5678);
    end
    bgnt = 1'b1;
    step(); step();
    check32("t3_grants", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) begin
      check32("t3_first", 32'(glog[0]), 32'(byte'("D")));
      check32("t3_second", 32'(glog[1]), 32'(byte'("I")));
    end
    drain();

    // 4: outstanding limit blocks issue until a response pops an entry.
    bgnt = 1'b1; brv = 1'b0; base = n_dgt;
    for (int k = 0; k < MAXO + 3; k++) begin
      if (!d_pend) begin d_pend = 1'b1; d_addr = 32'h3000 + 32'(k * 4); d_we = 1'b0; d_be = 4'hF; end
      step();
    end
    check32("t4_grants_at_limit", 32'(n_dgt - base), 32'(MAXO));
    check1("t4_req_blocked", mem_req_o, 1'b0);
    brv = 1'b1; brdata = 32'h5555_AAAA;
    step();
    check32("t4_no_bypass", 32'(n_dgt - base), 32'(MAXO));
    brv = 1'b0;
    step();
    check32("t4_grant_after_pop", 32'(n_dgt - base), 32'(MAXO + 1));
    drain();

    // 5: issue I, D, I; flush; only the data response surfaces.
    bgnt = 1'b1; brv = 1'b0;
    i_pend = 1'b1; i_addr = 32'h500; step();
    d_pend = 1'b1; d_addr = 32'h600; d_we = 1'b0; d_be = 4'hF; step();
    i_pend = 1'b1; i_addr = 32'h504; step();
    bgnt = 1'b0; flush = 1'b1; step();
    flush = 1'b0;
    base = n_drv;
    for (int k = 0; k < 3; k++) begin
      int base_i;
      base_i = n_irv;
      brv = 1'b1; brdata = 32'hD0 + 32'(k);
      step();
      check32("t5_data_rvalid", 32'(n_drv - base), (k >= 1) ? 32'd1 : 32'd0);
      check32("t5_instr_rvalid", 32'(n_irv - base_i), 32'd0);
    end
    brv = 1'b0;

    // 6: response with nothing outstanding sets a sticky error; reset clears it.
    brv = 1'b1; step();
    brv = 1'b0; step(); step();
    check1("t6_sticky", protocol_err_o, 1'b1);
    do_reset();
    check1("t6_cleared", protocol_err_o, 1'b0);
    bgnt = 1'b1; d_pend = 1'b1; d_addr = 32'h700; step();
    bgnt = 1'b0;
    do_reset();
    brv = 1'b1; step();
    brv = 1'b0; step();
    check1("t6_after_reset_err", protocol_err_o, 1'b1);
    do_reset();

    // Randomized traffic against the reference.
    mode = 2;
    for (int k = 0; k < 3000; k++) begin
      if (!i_pend && $urandom_range(0, 2) == 0) begin
        i_pend = 1'b1; i_addr = $urandom() & 32'hFFFF_FFFC;
      end
      if (!d_pend && $urandom_range(0, 1) == 0) begin
        d_pend = 1'b1; d_addr = $urandom(); d_we = $urandom_range(0, 1) == 1;
        d_be = 4'($urandom()); d_wdata = $urandom();
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
